// File: rtl/decode_pkg.sv
// Shared decode definitions for the ID stage.
// Contents: RV32I opcode constants, immediate-format selector, ALU operation
// codes, result-source codes, and helpers for immediate and ALU-op decode.
package decode_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_src_e;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLL   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_SLT   = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;

  // 32-bit immediate; the caller sign-extends to the datapath width.
  function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_src_e sel);
    logic [31:0] imm;
    case (sel)
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = {{20{instr[31]}}, instr[31:20]};
    endcase
    return imm;
  endfunction

  // Shared by R-type and I-ALU; only R-type may select SUB, both may select SRA.
  function automatic logic [3:0] alu_from_funct(input logic [2:0] funct3, input logic f7b5,
                                                input logic is_reg);
    logic [3:0] op;
    case (funct3)
      3'b000:  op = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_stage_pipe_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// master: upstream IF/ID register plus downstream EX (drives if_*, ex_ready).
// slave:  the decode stage (drives id_ready and the ID/EX register outputs).
interface decode_stage_pipe_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            if_valid;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  logic            id_ready;

  logic            ex_ready;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rd1;
  logic [XLEN-1:0] ex_rd2;
  logic [XLEN-1:0] ex_imm;
  logic [AW-1:0]   ex_rs1;
  logic [AW-1:0]   ex_rs2;
  logic [AW-1:0]   ex_rd;
  logic [2:0]      ex_funct3;
  logic [3:0]      ex_alu_ctrl;
  logic            ex_alu_src;
  logic [1:0]      ex_result_src;
  logic            ex_mem_write;
  logic            ex_reg_write;
  logic            ex_branch;
  logic            ex_jump;
  logic            ex_illegal;

  modport master (
    output if_valid, if_instr, if_pc, ex_ready,
    input  id_ready, ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_funct3, ex_alu_ctrl, ex_alu_src, ex_result_src, ex_mem_write,
           ex_reg_write, ex_branch, ex_jump, ex_illegal
  );

  modport slave (
    input  if_valid, if_instr, if_pc, ex_ready,
    output id_ready, ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_funct3, ex_alu_ctrl, ex_alu_src, ex_result_src, ex_mem_write,
           ex_reg_write, ex_branch, ex_jump, ex_illegal
  );
endinterface

// File: rtl/regfile_bypass.sv
// Architectural register file with two combinational read ports and one
// write port; x0 reads as zero, out-of-range indices are ignored/read zero,
// and (optionally) a same-cycle write is forwarded to the read ports.
// Ports: clk, reset (sync, high), we/waddr/wdata (write-back),
//        raddr1/raddr2 -> rdata1/rdata2.
module regfile_bypass #(
  parameter int  NREGS     = 32,
  parameter int  XLEN      = 32,
  parameter bit  BYPASS_WB = 1'b1,
  localparam int AW        = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] mem [NREGS];

  function automatic logic in_range(input logic [AW-1:0] a);
    return int'(a) < NREGS;
  endfunction

  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] a);
    logic [XLEN-1:0] d;
    if (a == '0 || !in_range(a))
      d = '0;
    else if (BYPASS_WB && we && waddr == a)
      d = wdata;
    else
      d = mem[a];
    return d;
  endfunction

  // NOTE: the whole array is cleared by reset, so it maps to flops rather than
  // a RAM macro; that is intended for a small architectural register file.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && waddr != '0 && in_range(waddr)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = read_port(raddr1);
  assign rdata2 = read_port(raddr2);

endmodule

// File: rtl/decode_stage_pipe.sv
// Pipelined RV32I decode stage: decodes one instruction per cycle, reads the
// register file (with optional write-back bypass), stalls one cycle on
// load-use hazards, and holds the result in an ID/EX register behind a
// valid/ready handshake.
// Ports: clk, reset (sync, high), flush (squash ID/EX),
//        wb_we/wb_rd/wb_data (register write-back),
//        bus (slave side: if_* in, id_ready out, ex_ready in, ex_* out).
module decode_stage_pipe
  import decode_pkg::*;
#(
  parameter int  XLEN      = 32,
  parameter int  NREGS     = 32,
  parameter bit  BYPASS_WB = 1'b1,
  localparam int AW        = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 wb_we,
  input  logic [AW-1:0]        wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  decode_stage_pipe_if.slave   bus
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   rd;
    logic [2:0]      funct3;
    logic [3:0]      alu_ctrl;
    logic            alu_src;
    logic [1:0]      result_src;
    logic            mem_write;
    logic            reg_write;
    logic            branch;
    logic            jump;
    logic            illegal;
  } id_ex_t;

  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            f7b5;
  logic [AW-1:0]   rs1, rs2, rd;
  logic [XLEN-1:0] rd1, rd2;

  assign instr  = bus.if_instr;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign f7b5   = instr[30];
  assign rs1    = AW'(instr[19:15]);
  assign rs2    = AW'(instr[24:20]);
  assign rd     = AW'(instr[11:7]);

  regfile_bypass #(
    .NREGS     (NREGS),
    .XLEN      (XLEN),
    .BYPASS_WB (BYPASS_WB)
  ) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .we     (wb_we),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rd1),
    .rdata2 (rd2)
  );

  // Control decode
  imm_src_e   imm_src;
  logic [3:0] alu_ctrl;
  logic [1:0] result_src;
  logic       alu_src, mem_write, reg_write, branch, jump, illegal;
  logic       uses_rs1, uses_rs2;

  // NOTE: every output gets a default before the case, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    imm_src    = IMM_I;
    alu_ctrl   = ALU_ADD;
    result_src = RES_ALU;
    alu_src    = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    illegal    = 1'b0;
    uses_rs1   = 1'b1;
    uses_rs2   = 1'b0;
    unique case (opcode)
      OP_R: begin
        uses_rs2  = 1'b1;
        reg_write = 1'b1;
        alu_ctrl  = alu_from_funct(funct3, f7b5, 1'b1);
      end
      OP_IMM: begin
        alu_src   = 1'b1;
        reg_write = 1'b1;
        alu_ctrl  = alu_from_funct(funct3, f7b5, 1'b0);
      end
      OP_LOAD: begin
        alu_src    = 1'b1;
        reg_write  = 1'b1;
        result_src = RES_MEM;
      end
      OP_STORE: begin
        uses_rs2  = 1'b1;
        alu_src   = 1'b1;
        mem_write = 1'b1;
        imm_src   = IMM_S;
      end
      OP_BRANCH: begin
        uses_rs2 = 1'b1;
        branch   = 1'b1;
        alu_ctrl = ALU_SUB;
        imm_src  = IMM_B;
      end
      OP_JAL: begin
        uses_rs1   = 1'b0;
        jump       = 1'b1;
        reg_write  = 1'b1;
        result_src = RES_PC4;
        imm_src    = IMM_J;
      end
      OP_JALR: begin
        alu_src    = 1'b1;
        jump       = 1'b1;
        reg_write  = 1'b1;
        result_src = RES_PC4;
      end
      OP_LUI: begin
        uses_rs1  = 1'b0;
        alu_src   = 1'b1;
        reg_write = 1'b1;
        alu_ctrl  = ALU_PASSB;
        imm_src   = IMM_U;
      end
      OP_AUIPC: begin
        uses_rs1  = 1'b0;
        alu_src   = 1'b1;
        reg_write = 1'b1;
        imm_src   = IMM_U;
      end
      default: begin
        illegal  = 1'b1;
        uses_rs1 = 1'b0;
      end
    endcase
  end

  // Handshake and load-use detection
  id_ex_t ex_q, ex_d;
  logic   advance, hazard;

  assign advance = bus.ex_ready || !ex_q.valid;
  // A load sitting in ID/EX cannot forward its data until after MEM, so a
  // dependent instruction waits one advancing cycle.
  assign hazard  = bus.if_valid && ex_q.valid && (ex_q.result_src == RES_MEM) &&
                   (ex_q.rd != '0) &&
                   ((uses_rs1 && rs1 == ex_q.rd) || (uses_rs2 && rs2 == ex_q.rd));
  assign bus.id_ready = flush || (advance && !hazard);

  always_comb begin
    ex_d            = '0;
    ex_d.valid      = 1'b1;
    ex_d.pc         = bus.if_pc;
    ex_d.rd1        = rd1;
    ex_d.rd2        = rd2;
    ex_d.imm        = XLEN'($signed(imm_gen(instr, imm_src)));
    ex_d.rs1        = rs1;
    ex_d.rs2        = rs2;
    ex_d.rd         = rd;
    ex_d.funct3     = funct3;
    ex_d.alu_ctrl   = alu_ctrl;
    ex_d.alu_src    = alu_src;
    ex_d.result_src = result_src;
    ex_d.mem_write  = mem_write;
    ex_d.reg_write  = reg_write;
    ex_d.branch     = branch;
    ex_d.jump       = jump;
    ex_d.illegal    = illegal;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q <= '0;
    end else if (flush || (advance && (hazard || !bus.if_valid))) begin
      // Bubble: side-effecting flags are cleared so a stale slot can never
      // write a register or memory even if valid were ignored downstream.
      ex_q.valid     <= 1'b0;
      ex_q.reg_write <= 1'b0;
      ex_q.mem_write <= 1'b0;
    end else if (advance) begin
      ex_q <= ex_d;
    end
  end

  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_pc         = ex_q.pc;
  assign bus.ex_rd1        = ex_q.rd1;
  assign bus.ex_rd2        = ex_q.rd2;
  assign bus.ex_imm        = ex_q.imm;
  assign bus.ex_rs1        = ex_q.rs1;
  assign bus.ex_rs2        = ex_q.rs2;
  assign bus.ex_rd         = ex_q.rd;
  assign bus.ex_funct3     = ex_q.funct3;
  assign bus.ex_alu_ctrl   = ex_q.alu_ctrl;
  assign bus.ex_alu_src    = ex_q.alu_src;
  assign bus.ex_result_src = ex_q.result_src;
  assign bus.ex_mem_write  = ex_q.mem_write;
  assign bus.ex_reg_write  = ex_q.reg_write;
  assign bus.ex_branch     = ex_q.branch;
  assign bus.ex_jump       = ex_q.jump;
  assign bus.ex_illegal    = ex_q.illegal;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Self-checking bench for decode_stage_pipe: a table of decode vectors is
// streamed through a scoreboard, followed by hand sequences for load-use,
// write-back bypass, backpressure, flush and mid-stream reset.
module tb_decode_stage_pipe;

  // mask bits: [3] imm, [2] alu_src, [1] alu_ctrl, [0] result_src
  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic        alu_src;
    logic [1:0]  res;
    logic [4:0]  flags; // {mem_write, reg_write, branch, jump, illegal}
    logic [3:0]  mask;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, flush, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  exp_t        exp_q[$];
  logic [31:0] model [32];

  decode_stage_pipe_if #(.XLEN(32), .AW(5)) bus ();
  decode_stage_pipe_if #(.XLEN(32), .AW(5)) bus_nb ();

  assign bus_nb.if_valid = bus.if_valid;
  assign bus_nb.if_instr = bus.if_instr;
  assign bus_nb.if_pc    = bus.if_pc;
  assign bus_nb.ex_ready = bus.ex_ready;

  decode_stage_pipe #(.XLEN(32), .NREGS(32), .BYPASS_WB(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .bus(bus.slave)
  );

  decode_stage_pipe #(.XLEN(32), .NREGS(32), .BYPASS_WB(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .bus(bus_nb.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] imm,
                              input logic [3:0] alu, input logic alu_src,
                              input logic [1:0] res, input logic [4:0] flags,
                              input logic [3:0] mask);
    vec_t v;
    v.instr = instr; v.imm = imm; v.alu = alu; v.alu_src = alu_src;
    v.res = res; v.flags = flags; v.mask = mask;
    return v;
  endfunction

  // Reference register file with write-back bypass.
  function automatic logic [31:0] model_rd(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (wb_we && wb_rd == idx) return wb_data;
    return model[idx];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] <= 32'd0;
    end else if (wb_we && wb_rd != 5'd0) begin
      model[wb_rd] <= wb_data;
    end
  end

  task automatic push_exp(input vec_t v, input logic [31:0] pc);
    exp_t e;
    e.v   = v;
    e.pc  = pc;
    e.rd1 = model_rd(v.instr[19:15]);
    e.rd2 = model_rd(v.instr[24:20]);
    exp_q.push_back(e);
  endtask

  // Present an instruction until accepted (bounded); record it in the scoreboard.
  task automatic issue(input vec_t v, input logic [31:0] pc, output int stalls);
    logic accepted;
    accepted = 1'b0;
    stalls = 0;
    bus.if_valid = 1'b1;
    bus.if_instr = v.instr;
    bus.if_pc    = pc;
    for (int n = 0; n < 20 && !accepted; n++) begin
      @(negedge clk);
      if (bus.id_ready && !flush) begin
        push_exp(v, pc);
        accepted = 1'b1;
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
    end
    if (!accepted) check($sformatf("issue_accept_pc%0h", pc), accepted, 1'b1);
    bus.if_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.if_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
    wb_we = 1'b1; wb_rd = r; wb_data = d;
    @(posedge clk);
    #1;
    wb_we = 1'b0;
  endtask

  // Scoreboard consumer: compares whatever EX takes this cycle.
  always @(negedge clk) begin
    if (!reset && bus.ex_valid && bus.ex_ready) begin
      check("sb_has_entry", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        exp_t  e;
        string p;
        e = exp_q.pop_front();
        p = $sformatf("pc%0h_", e.pc);
        check({p, "pc"}, bus.ex_pc, e.pc);
        check({p, "rd1"}, bus.ex_rd1, e.rd1);
        check({p, "rd2"}, bus.ex_rd2, e.rd2);
        check({p, "rs1"}, bus.ex_rs1, e.v.instr[19:15]);
        check({p, "rs2"}, bus.ex_rs2, e.v.instr[24:20]);
        check({p, "rd"}, bus.ex_rd, e.v.instr[11:7]);
        check({p, "funct3"}, bus.ex_funct3, e.v.instr[14:12]);
        check({p, "flags"}, {bus.ex_mem_write, bus.ex_reg_write, bus.ex_branch,
                             bus.ex_jump, bus.ex_illegal}, e.v.flags);
        if (e.v.mask[3]) check({p, "imm"}, bus.ex_imm, e.v.imm);
        if (e.v.mask[2]) check({p, "alu_src"}, bus.ex_alu_src, e.v.alu_src);
        if (e.v.mask[1]) check({p, "alu_ctrl"}, bus.ex_alu_ctrl, e.v.alu);
        if (e.v.mask[0]) check({p, "result_src"}, bus.ex_result_src, e.v.res);
      end
    end
  end

  initial begin
    vec_t tbl[15];
    vec_t v_lw0, v_add_x7, v_sub, v_or, v_xor, v_addi;
    int   stalls, total_stalls;

    //                 instr         imm           alu    src  res   flags     mask
    tbl[0]  = mk(32'h00728313, 32'h00000007, 4'b0000, 1'b1, 2'd0, 5'b01000, 4'b1111); // addi x6,x5,7
    tbl[1]  = mk(32'h00208433, 32'h0,        4'b0000, 1'b0, 2'd0, 5'b01000, 4'b0111); // add
    tbl[2]  = mk(32'h402084B3, 32'h0,        4'b0001, 1'b0, 2'd0, 5'b01000, 4'b0111); // sub
    tbl[3]  = mk(32'h4020D533, 32'h0,        4'b0111, 1'b0, 2'd0, 5'b01000, 4'b0111); // sra
    tbl[4]  = mk(32'h4030D593, 32'h00000403, 4'b0111, 1'b1, 2'd0, 5'b01000, 4'b1111); // srai
    tbl[5]  = mk(32'hFFF0A613, 32'hFFFFFFFF, 4'b1000, 1'b1, 2'd0, 5'b01000, 4'b1111); // slti -1
    tbl[6]  = mk(32'h0020B6B3, 32'h0,        4'b1001, 1'b0, 2'd0, 5'b01000, 4'b0111); // sltu
    tbl[7]  = mk(32'h0080A383, 32'h00000008, 4'b0000, 1'b1, 2'd1, 5'b01000, 4'b1111); // lw x7,8(x1)
    tbl[8]  = mk(32'hFE20AE23, 32'hFFFFFFFC, 4'b0000, 1'b1, 2'd0, 5'b10000, 4'b1110); // sw x2,-4(x1)
    tbl[9]  = mk(32'hFE208EE3, 32'hFFFFFFFC, 4'b0001, 1'b0, 2'd0, 5'b00100, 4'b1110); // beq -4
    tbl[10] = mk(32'h001000EF, 32'h00000800, 4'b0000, 1'b0, 2'd2, 5'b01010, 4'b1001); // jal 2048
    tbl[11] = mk(32'h00008067, 32'h00000000, 4'b0000, 1'b1, 2'd2, 5'b01010, 4'b1111); // jalr
    tbl[12] = mk(32'h12345737, 32'h12345000, 4'b1010, 1'b1, 2'd0, 5'b01000, 4'b1111); // lui
    tbl[13] = mk(32'hFFFFF797, 32'hFFFFF000, 4'b0000, 1'b1, 2'd0, 5'b01000, 4'b1111); // auipc
    tbl[14] = mk(32'h0000007F, 32'h0,        4'b0000, 1'b0, 2'd0, 5'b00001, 4'b0000); // illegal

    v_addi   = tbl[0];
    v_lw0    = mk(32'h0000A383, 32'h0, 4'b0000, 1'b1, 2'd1, 5'b01000, 4'b1111);
    v_add_x7 = mk(32'h00238433, 32'h0, 4'b0000, 1'b0, 2'd0, 5'b01000, 4'b0111);
    v_sub    = mk(32'h40318233, 32'h0, 4'b0001, 1'b0, 2'd0, 5'b01000, 4'b0111);
    v_or     = mk(32'h0020E833, 32'h0, 4'b0011, 1'b0, 2'd0, 5'b01000, 4'b0111);
    v_xor    = mk(32'h0020C8B3, 32'h0, 4'b0100, 1'b0, 2'd0, 5'b01000, 4'b0111);

    reset = 1'b1; flush = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    bus.if_valid = 1'b0; bus.if_instr = '0; bus.if_pc = '0; bus.ex_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_ex_valid", bus.ex_valid, 1'b0);
    check("rst_ex_pc", bus.ex_pc, 32'd0);
    check("rst_ex_rd1", bus.ex_rd1, 32'd0);
    check("rst_ex_imm", bus.ex_imm, 32'd0);
    check("rst_ex_alu_ctrl", bus.ex_alu_ctrl, 4'd0);
    check("rst_ex_reg_write", bus.ex_reg_write, 1'b0);
    check("rst_id_ready", bus.id_ready, 1'b1);
    @(posedge clk);
    #1;

    wb_write(5'd1, 32'h00001000);
    wb_write(5'd2, 32'h00000020);
    wb_write(5'd3, 32'h00000055);
    wb_write(5'd5, 32'h00001234);

    // Decode table, back-to-back with EX always ready
    total_stalls = 0;
    foreach (tbl[i]) begin
      issue(tbl[i], 32'h100 + 32'(i) * 4, stalls);
      total_stalls += stalls;
    end
    check("table_no_stalls", total_stalls, 0);
    idle(3);
    check("table_drained", exp_q.size(), 0);

    // Load-use: one bubble, then the dependent add issues
    issue(v_lw0, 32'h200, stalls);
    bus.if_valid = 1'b1; bus.if_instr = v_add_x7.instr; bus.if_pc = 32'h204;
    @(negedge clk);
    check("lu_stall_id_ready", bus.id_ready, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("lu_bubble_ex_valid", bus.ex_valid, 1'b0);
    check("lu_bubble_reg_write", bus.ex_reg_write, 1'b0);
    check("lu_issue_id_ready", bus.id_ready, 1'b1);
    push_exp(v_add_x7, 32'h204);
    @(posedge clk);
    #1;
    idle(3);

    // Write-back bypass in the issue cycle
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h0000DEAD;
    issue(v_sub, 32'h300, stalls);
    wb_we = 1'b0;
    @(negedge clk);
    check("nobyp_ex_valid", bus_nb.ex_valid, 1'b1);
    check("nobyp_rd1", bus_nb.ex_rd1, 32'h00000055);
    check("nobyp_rd2", bus_nb.ex_rd2, 32'h00000055);
    idle(3);

    // Backpressure: ID/EX holds for 3 cycles, fetch stalls
    bus.ex_ready = 1'b0;
    issue(v_or, 32'h400, stalls);
    bus.if_valid = 1'b1; bus.if_instr = v_xor.instr; bus.if_pc = 32'h404;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("bp%0d_id_ready", c), bus.id_ready, 1'b0);
      check($sformatf("bp%0d_ex_valid", c), bus.ex_valid, 1'b1);
      check($sformatf("bp%0d_ex_pc", c), bus.ex_pc, 32'h400);
      check($sformatf("bp%0d_ex_alu", c), bus.ex_alu_ctrl, 4'b0011);
      @(posedge clk);
      #1;
    end
    bus.ex_ready = 1'b1;
    issue(v_xor, 32'h404, stalls);
    check("bp_release_stalls", stalls, 0);
    idle(3);

    // Flush with a held entry and a valid input instruction
    bus.ex_ready = 1'b0;
    issue(v_or, 32'h500, stalls);
    bus.if_valid = 1'b1; bus.if_instr = v_xor.instr; bus.if_pc = 32'h504;
    flush = 1'b1;
    @(negedge clk);
    check("flush_id_ready", bus.id_ready, 1'b1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.if_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flush_ex_valid", bus.ex_valid, 1'b0);
    check("flush_reg_write", bus.ex_reg_write, 1'b0);
    @(posedge clk);
    #1;

    // Reset mid-stream with a valid entry held in ID/EX
    issue(tbl[12], 32'h600, stalls);
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("mrst_ex_valid", bus.ex_valid, 1'b0);
    check("mrst_ex_pc", bus.ex_pc, 32'd0);
    check("mrst_ex_imm", bus.ex_imm, 32'd0);
    check("mrst_ex_alu", bus.ex_alu_ctrl, 4'd0);
    check("mrst_ex_rd", bus.ex_rd, 5'd0);
    check("mrst_ex_reg_write", bus.ex_reg_write, 1'b0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.ex_ready = 1'b1;
    // x5 was cleared by reset, so rd1 is expected to be 0
    issue(v_addi, 32'h700, stalls);
    idle(3);
    check("final_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
Parametrised, pipelined RV32I-style decode stage. Decodes one instruction per cycle, reads a built-in register file with write-back bypass, and detects load-use hazards. Results land in an ID/EX pipeline register with a valid/ready handshake. Sits between the IF/ID register and the execute stage; replaces the single-cycle decode path.

Parameters:
XLEN, 32, datapath/PC width; immediates sign-extended to XLEN
NREGS, 32, architectural register count; AW = clog2(NREGS); register 0 is hardwired zero
BYPASS_WB, 1, 1 = same-cycle write-back data forwarded to read ports; 0 = read stored value only

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
if_valid  in  1  instruction on if_* is valid
if_instr  in  32  instruction word
if_pc  in  XLEN  instruction PC
id_ready  out  1  stage accepts if_* this cycle (combinational)
flush  in  1  squash ID/EX contents (taken branch/jump from EX)
wb_we  in  1  write-back enable
wb_rd  in  AW  write-back register index
wb_data  in  XLEN  write-back data
ex_ready  in  1  EX accepts ID/EX contents this cycle
ex_valid  out  1  ID/EX holds a real instruction
ex_pc  out  XLEN  registered PC
ex_rd1, ex_rd2  out  XLEN  registered operands
ex_imm  out  XLEN  registered sign-extended immediate
ex_rs1, ex_rs2, ex_rd  out  AW  registered register indices
ex_funct3  out  3  registered funct3 (branch/load/store size)
ex_alu_ctrl  out  4  ALU operation code
ex_alu_src  out  1  1 = operand B is ex_imm
ex_result_src  out  2  0 ALU, 1 memory, 2 PC+4
ex_mem_write, ex_reg_write, ex_branch, ex_jump, ex_illegal  out  1 each  control flags

Behaviour:
- Reset (sync, high): ex_valid=0; all ex_* outputs=0; all registers cleared to 0.
- advance = ex_ready | ~ex_valid.
- hazard = if_valid & ex_valid & (ex_result_src==1) & ex_rd!=0 & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)).
- id_ready = flush | (advance & ~hazard).
- Clock edge, in priority order:
  - reset
  - flush: ex_valid<=0; the on-input instruction is consumed and dropped.
  - advance & (hazard | ~if_valid): bubble; ex_valid<=0; other ex_* don't-care but ex_reg_write and ex_mem_write <=0.
  - advance: latch decoded fields; ex_valid<=1.
  - otherwise hold all ex_*.
- Latency: one cycle from accept (if_valid & id_ready) to ex_valid.
- Load-use: stall exactly one advancing cycle, then issue with forwarding left to EX.
- Decode:
  - Opcodes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
  - uses_rs1 is false for LUI, AUIPC and JAL.
  - uses_rs2 is true only for R, STORE and BRANCH.
  - Any other opcode: ex_illegal=1; reg_write, mem_write, branch and jump=0.
- Immediates: I/S/B/U/J formats; B and J have bit0=0; U is imm[31:12]<<12; sign-extend bit31 to XLEN.
- ALU codes:
  - ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001, PASSB 1010.
  - SUB only for R with funct7[5]=1.
  - SRA when funct3=101 and funct7[5]=1.
  - Loads, stores, JALR and AUIPC use ADD; LUI uses PASSB; branches use SUB.
- Register file:
  - Writes at the clock edge when wb_we & wb_rd!=0.
  - Reads of index 0 return 0.
  - BYPASS_WB=1: a read with index == wb_rd, wb_we=1 and wb_rd!=0 returns wb_data in the same cycle.
  - Writes continue during stall and flush.
  - Indices >= NREGS: writes ignored, reads return 0.

Decomposition:
- decode_pkg holds:
  - opcode constants
  - ImmSrc encoding (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J)
  - ALU code constants
  - result_src constants
- Sub-module regfile_bypass (NREGS, XLEN, BYPASS_WB) covers the register array, reset, x0 rule and the bypass mux.
- Decode logic and the ID/EX register stay in the top.

Test Plan:
- After reset, write x5=0x1234 via wb, then issue addi x6,x5,7 (0x00728313) -> next cycle ex_valid=1, ex_rd1=0x1234, ex_imm=7, ex_alu_ctrl=0000, ex_alu_src=1, ex_reg_write=1.
- lw x7,0(x1) then add x8,x7,x2 back-to-back, ex_ready=1 -> id_ready=0 for one cycle, bubble (ex_valid=0), then the add issues with ex_rs1=7.
- wb_we=1, wb_rd=3, wb_data=0xDEAD in the same cycle as issuing sub x4,x3,x3 -> ex_rd1=ex_rd2=0xDEAD, ex_alu_ctrl=0001; with BYPASS_WB=0 the operands hold the old value.
- ex_ready=0 for 3 cycles while valid -> ex_* stable and id_ready=0; then ex_ready=1 -> next instruction latched.
- flush=1 with if_valid=1 -> ex_valid=0 next cycle and id_ready=1 that cycle; then assert reset mid-stream -> all ex_* =0 next edge and reads of x5 return 0.
- Opcode 0x7F and beq x1,x2,-4 (0xFE208EE3) -> first gives ex_illegal=1 with ex_reg_write=0; second gives ex_branch=1, ex_imm=0xFFFFFFFC.
